aes_inv_key_sched: RTL and testbench



---
 rtl/aes_inv_key_sched_if.sv | 25 ++
 rtl/aes_inv_key_sched.sv | 135 +++++++++++++
 tb/tb_aes_inv_key_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_sched_if.sv
// Stream and S-box port bundle for the inverse AES-128 key-schedule engine.
// The master side is the key-schedule engine; the slave side is its
// environment (controller, round datapath and the external S-boxes).
interface aes_inv_key_sched_if;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;

  modport master (
    input  start, last_key, rk_ready, sbox_out,
    output rk, rk_round, rk_valid, busy, done, sbox_in
  );

  modport slave (
    output start, last_key, rk_ready, sbox_out,
    input  rk, rk_round, rk_valid, busy, done, sbox_in
  );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule.
// Loads the last round key and walks the expansion backwards, emitting round
// keys NUM_ROUNDS down to 0 on a valid/ready stream. Substitution is done by
// four external combinational S-boxes reached through sbox_in/sbox_out.
module aes_inv_key_sched #(
  parameter int         NUM_ROUNDS = 10,
  parameter logic [7:0] RCON_LAST  = 8'h36
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_inv_key_sched_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] kreg_q, kreg_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, t;
  logic [127:0] kreg_prev;
  logic         handshake;

  // Reverse round-constant step; any unexpected value collapses to 0 so the
  // register can never carry an unknown forward.
  function automatic logic [7:0] prev_rcon(input logic [7:0] rc);
    logic [7:0] r;
    case (rc)
      8'h36:   r = 8'h1b;
      8'h1b:   r = 8'h80;
      8'h80:   r = 8'h40;
      8'h40:   r = 8'h20;
      8'h20:   r = 8'h10;
      8'h10:   r = 8'h08;
      8'h08:   r = 8'h04;
      8'h04:   r = 8'h02;
      8'h02:   r = 8'h01;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign w0 = kreg_q[127:96];
  assign w1 = kreg_q[95:64];
  assign w2 = kreg_q[63:32];
  assign w3 = kreg_q[31:0];

  // t is the previous round's w3; its rotated form feeds the S-boxes.
  assign t         = w3 ^ w2;
  assign bus.sbox_in = {t[23:0], t[31:24]};

  // One backwards expansion step from the current key to the previous one.
  always_comb begin
    kreg_prev = {w0 ^ bus.sbox_out ^ {rcon_q, 24'h0}, w1 ^ w0, w2 ^ w1, t};
  end

  assign handshake = valid_q & bus.rk_ready;

  // Next-state logic for the walk controller and key register.
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = EMIT;
          kreg_d  = bus.last_key;
          round_d = 4'(NUM_ROUNDS);
          rcon_d  = RCON_LAST;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (round_q != 4'd0) begin
            kreg_d  = kreg_prev;
            round_d = round_q - 4'd1;
            rcon_d  = prev_rcon(rcon_q);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything, including the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      round_q <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk       = kreg_q;
  assign bus.rk_round = round_q;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for the inverse AES-128 key schedule: FIPS-197 A.1 key walk with
// continuous ready, random backpressure, mid-walk reset, ignored and
// back-to-back start, and rcon boundary behaviour.
module tb_aes_inv_key_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  aes_inv_key_sched_if bus();

  aes_inv_key_sched #(
    .NUM_ROUNDS (10),
    .RCON_LAST  (8'h36)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    logic [7:0]   rcon;
  } vec_t;

  vec_t vecs[11];

  localparam logic [127:0] KEY_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] KEY_R9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] KEY_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] KEY_R0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

  // GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Behavioural AES S-box: multiplicative inverse followed by the affine map.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  always_comb begin
    bus.sbox_out = subword(bus.sbox_in);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Forward key expansion from the round-0 key, used for the middle rounds.
  task automatic build_vectors();
    logic [31:0] w[44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [7:0]  rcon_seq[11];
    rcon_seq = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10,
                 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};
    w[0] = KEY_R0[127:96];
    w[1] = KEY_R0[95:64];
    w[2] = KEY_R0[63:32];
    w[3] = KEY_R0[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 11; n++) begin
      vecs[n].rnd  = 4'(10 - n);
      vecs[n].key  = {w[4*(10-n)], w[4*(10-n)+1], w[4*(10-n)+2], w[4*(10-n)+3]};
      vecs[n].rcon = rcon_seq[n];
    end
    vecs[0].key  = KEY_R10;
    vecs[1].key  = KEY_R9;
    vecs[9].key  = KEY_R1;
    vecs[10].key = KEY_R0;
  endtask

  // Pulse start with the given key and check the first key appears next cycle.
  task automatic start_pulse(input logic [127:0] k);
    bus.last_key = k;
    bus.start    = 1'b1;
    step();
    bus.start    = 1'b0;
    chk("first_valid", 128'(bus.rk_valid), 128'(1'b1));
    chk("first_busy", 128'(bus.busy), 128'(1'b1));
    chk("first_round", 128'(bus.rk_round), 128'(4'd10));
    chk("first_key", bus.rk, k);
    chk("first_rcon", 128'(dut.rcon_q), 128'(8'h36));
  endtask

  // Consume keys with the given ready duty until max_hs handshakes are done.
  // Optionally pokes start while the key of poke_round is on the bus.
  task automatic walk(input int pct, input int max_hs, input int poke_round, output int cyc);
    int           hs;
    logic         stall;
    logic         rdy;
    logic [127:0] hk;
    logic [3:0]   hr;
    bit           poked;
    hs    = 0;
    cyc   = 0;
    stall = 1'b0;
    poked = 1'b0;
    hk    = '0;
    hr    = '0;
    while (hs < max_hs && cyc < 300) begin
      chk("valid_in_walk", 128'(bus.rk_valid), 128'(1'b1));
      if (stall) begin
        chk("hold_rk", bus.rk, hk);
        chk("hold_round", 128'(bus.rk_round), 128'(hr));
      end
      bus.start = 1'b0;
      if (!poked && poke_round >= 0 && bus.rk_round == 4'(poke_round)) begin
        bus.start    = 1'b1;
        bus.last_key = {128{1'b1}};
        poked        = 1'b1;
      end
      rdy = (int'($urandom_range(0, 99)) < pct);
      bus.rk_ready = rdy;
      if (bus.rk_valid && rdy) begin
        chk("key", bus.rk, vecs[hs].key);
        chk("round", 128'(bus.rk_round), 128'(vecs[hs].rnd));
        chk("rcon", 128'(dut.rcon_q), 128'(vecs[hs].rcon));
        hs++;
      end
      stall = bus.rk_valid && !rdy;
      hk    = bus.rk;
      hr    = bus.rk_round;
      step();
      cyc++;
    end
    bus.start = 1'b0;
    if (hs < max_hs) begin
      n_cmp++;
      n_bad++;
      $display("FAIL walk_timeout: got %0d handshakes required %0d", hs, max_hs);
    end
    if (max_hs == 11) begin
      chk("done_pulse", 128'(bus.done), 128'(1'b1));
      chk("done_busy", 128'(bus.busy), 128'(1'b0));
      chk("done_valid", 128'(bus.rk_valid), 128'(1'b0));
    end
  endtask

  initial begin
    int cyc;
    n_cmp        = 0;
    n_bad        = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.last_key = '0;
    bus.rk_ready = 1'b0;
    build_vectors();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("rst_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_done", 128'(bus.done), 128'(1'b0));
    chk("rst_rk", bus.rk, 128'h0);
    chk("rst_round", 128'(bus.rk_round), 128'(4'd0));
    chk("rst_rcon", 128'(dut.rcon_q), 128'(8'h00));
    rst = 1'b0;
    step();

    // Continuous ready: 11 back-to-back keys
    start_pulse(KEY_R10);
    walk(100, 11, -1, cyc);
    chk("consecutive_cycles", 128'(cyc), 128'(11));
    bus.rk_ready = 1'b1;
    step();
    chk("done_once", 128'(bus.done), 128'(1'b0));
    chk("idle_ready_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("idle_ready_round", 128'(bus.rk_round), 128'(4'd0));
    chk("idle_ready_rk", bus.rk, KEY_R0);
    step();
    chk("rcon_hold", 128'(dut.rcon_q), 128'(8'h00));
    bus.rk_ready = 1'b0;

    // Random backpressure
    start_pulse(KEY_R10);
    walk(30, 11, -1, cyc);
    step();
    chk("bp_done_once", 128'(bus.done), 128'(1'b0));

    // Reset after the round-6 key is accepted
    start_pulse(KEY_R10);
    walk(100, 5, -1, cyc);
    rst = 1'b1;
    bus.rk_ready = 1'b1;
    step();
    chk("midrst_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("midrst_busy", 128'(bus.busy), 128'(1'b0));
    chk("midrst_done", 128'(bus.done), 128'(1'b0));
    chk("midrst_round", 128'(bus.rk_round), 128'(4'd0));
    rst = 1'b0;
    repeat (3) step();
    chk("midrst_no_keys", 128'(bus.rk_valid), 128'(1'b0));
    chk("midrst_no_done", 128'(bus.done), 128'(1'b0));
    start_pulse(KEY_R10);
    walk(100, 11, -1, cyc);
    step();

    // Start ignored at round 8, then restart in the done cycle
    start_pulse(KEY_R10);
    walk(100, 11, 8, cyc);
    start_pulse(KEY_R10);
    chk("b2b_done_cleared", 128'(bus.done), 128'(1'b0));
    walk(60, 11, -1, cyc);
    step();
    chk("b2b_single_done", 128'(bus.done), 128'(1'b0));

    // Start coincident with reset
    bus.last_key = KEY_R10;
    bus.start    = 1'b1;
    rst          = 1'b1;
    step();
    bus.start = 1'b0;
    rst       = 1'b0;
    chk("rst_start_valid", 128'(bus.rk_valid), 128'(1'b0));
    chk("rst_start_busy", 128'(bus.busy), 128'(1'b0));
    chk("rst_start_rcon", 128'(dut.rcon_q), 128'(8'h00));
    step();
    chk("rst_start_idle", 128'(bus.rk_valid), 128'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
